axis_frame_generator: RTL and testbench
=======================================

AXIS_FRAME_GENERATOR -- requirements
Module: axis_frame_generator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning stream data width in bits, a multiple of 8.
REQ-002 SHALL have parameter LEN_WIDTH, default 12, meaning frame-length field width in beats.
REQ-003 SHALL use one clock and a synchronous, active-high reset: m01_axis_aclk  in  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have m01_axis_areset  in  1  synchronous active-high reset.
REQ-005 SHALL have start  in  1  single-cycle request to begin a frame.
REQ-006 SHALL have frame_len  in  LEN_WIDTH  beats per frame, sampled with start.
REQ-007 SHALL have seed  in  DATA_WIDTH  first data word of the frame, sampled with start.
REQ-008 SHALL have m01_axis_tdata  out  DATA_WIDTH  generated data.
REQ-009 SHALL have m01_axis_tstrb  out  DATA_WIDTH/8  byte strobes.
REQ-010 SHALL have m01_axis_tvalid  out  1, m01_axis_tlast  out  1, and m01_axis_tready  in  1, meaning AXI-Stream master handshake.
REQ-011 SHALL have s01_axis_tdata  in  DATA_WIDTH, s01_axis_tvalid  in  1, s01_axis_tlast  in  1, and s01_axis_tready  out  1, meaning loop-back receive stream.
REQ-012 SHALL have busy  out  1, tx_done  out  1 (pulse), rx_done  out  1 (pulse), and err_count  out  16, meaning status.

Function
REQ-013 SHALL implement TX FSM states IDLE and SEND.
- IDLE -> SEND when start=1 and frame_len!=0; latch frame_len and seed; clear beat index.
- start with frame_len=0: ignored, stays IDLE.
REQ-014 In SEND, SHALL drive m01_axis_tvalid=1 and m01_axis_tdata=seed_latched+beat_idx (modulo 2^DATA_WIDTH), with m01_axis_tstrb all ones.
REQ-015 SHALL hold tdata, tlast and tvalid stable while tvalid=1 and tready=0; beat_idx advances only on tvalid&&tready.
REQ-016 SHALL assert m01_axis_tlast exactly when beat_idx==len_latched-1.
REQ-017 On the tlast handshake, SHALL return to IDLE next cycle with tvalid=0 and pulse tx_done for one cycle.
REQ-018 SHALL ignore start while in SEND and SHALL NOT alter the latched len or seed.
REQ-019 SHALL drive busy=1 in SEND, 0 in IDLE; first tvalid appears the cycle after start is sampled (latency 1).
REQ-020 SHALL make the RX checker always ready: s01_axis_tready=1 except during reset.
REQ-021 On each s01 handshake, SHALL compare s01_axis_tdata with seed_latched+rx_idx and increment err_count on mismatch.
REQ-022 SHALL count a tlast error when tlast=1 and rx_idx!=len_latched-1, or when tlast=0 and rx_idx==len_latched-1; a data error and a tlast error on the same beat count as one.
REQ-023 On a beat with s01_axis_tlast=1, SHALL clear rx_idx and pulse rx_done for one cycle; otherwise rx_idx increments, wrapping at 2^LEN_WIDTH.
REQ-024 SHALL saturate err_count at 16'hFFFF.
REQ-025 SHALL clear rx_idx on start acceptance; err_count is cleared only by reset.

Reset
REQ-026 While m01_axis_areset=1 at a clock edge, SHALL force the FSM to IDLE, clear beat_idx, rx_idx, len_latched, seed_latched and err_count, and drive tvalid=0, tlast=0, tdata=0, tstrb=0, s01_axis_tready=0, busy=0, tx_done=0 and rx_done=0.
REQ-027 SHALL abort a frame on reset mid-frame without emitting a tlast, and SHALL resume normal operation on the first cycle after reset deasserts.

Configuration
REQ-028 SHALL compile the RX checker only when macro AXIS_FRAME_CHECKER_EN is defined.
- Without the macro: s01_axis_tready=1 (0 in reset), err_count=0 and rx_done=0 constantly, and s01 inputs are unused.

Verification
REQ-029 Bench SHALL check: seed=32'h10, len=4, tready=1 -> tdata 10,11,12,13 on consecutive cycles, tlast on 13, tx_done the cycle after.
REQ-030 Bench SHALL check: tready toggled 1-0-1-0 during a len=3 frame -> no beat lost or duplicated and data held stable while stalled.
REQ-031 Bench SHALL check: start with len=0 -> tvalid stays 0 and busy stays 0.
REQ-032 Bench SHALL check: loop-back of a seed=32'hFFFF_FFFE, len=3 frame -> data FFFFFFFE, FFFFFFFF, 0, rx_done pulses, err_count=0.
REQ-033 Bench SHALL check: loop-back with beat 1 corrupted and tlast early on beat 1 of a len=4 frame -> err_count=1 and rx_idx cleared.
REQ-034 Bench SHALL check: reset asserted on beat 2 of a len=8 frame -> tvalid=0 next cycle, err_count=0, and a subsequent start works normally.

Source files
------------

// File: rtl/axis_frame_generator.sv
// axis_frame_generator: AXI-Stream frame source with an optional loop-back checker.
// The TX side emits frames of frame_len beats whose data counts up from seed.
// Define AXIS_FRAME_CHECKER_EN to build the RX checker. Without it, err_count and
// rx_done are tied to zero, s01 inputs are ignored and s01_axis_tready only
// follows reset.
module axis_frame_generator #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                      m01_axis_aclk,
    input  logic                      m01_axis_areset,
    input  logic                      start,
    input  logic [LEN_WIDTH-1:0]      frame_len,
    input  logic [DATA_WIDTH-1:0]     seed,
    output logic [DATA_WIDTH-1:0]     m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m01_axis_tstrb,
    output logic                      m01_axis_tvalid,
    output logic                      m01_axis_tlast,
    input  logic                      m01_axis_tready,
    input  logic [DATA_WIDTH-1:0]     s01_axis_tdata,
    input  logic                      s01_axis_tvalid,
    input  logic                      s01_axis_tlast,
    output logic                      s01_axis_tready,
    output logic                      busy,
    output logic                      tx_done,
    output logic                      rx_done,
    output logic [15:0]               err_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    tx_state_t             state;
    tx_state_t             state_next;

    logic [LEN_WIDTH-1:0]  beat_idx;
    logic [LEN_WIDTH-1:0]  len_latched;
    logic [DATA_WIDTH-1:0] seed_latched;
    logic                  start_accept;
    logic                  beat_advance;
    logic                  last_handshake;
    logic                  beat_is_last;
    logic                  tx_done_q;

    assign beat_is_last = (beat_idx == (len_latched - LEN_WIDTH'(1)));

    // TX state register
    always_ff @(posedge m01_axis_aclk) begin
        if (m01_axis_areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // TX next-state decode and stream outputs; outputs stay stable during a stall
    // because they depend only on registered frame context
    always_comb begin
        state_next      = state;
        start_accept    = 1'b0;
        beat_advance    = 1'b0;
        last_handshake  = 1'b0;
        m01_axis_tvalid = 1'b0;
        m01_axis_tlast  = 1'b0;
        m01_axis_tdata  = '0;
        m01_axis_tstrb  = '0;
        busy            = 1'b0;
        case (state)
            IDLE: begin
                if (start && (frame_len != '0)) begin
                    state_next   = SEND;
                    start_accept = 1'b1;
                end
            end
            SEND: begin
                busy            = 1'b1;
                m01_axis_tvalid = 1'b1;
                m01_axis_tstrb  = '1;
                m01_axis_tdata  = seed_latched + DATA_WIDTH'(beat_idx);
                m01_axis_tlast  = beat_is_last;
                if (m01_axis_tready) begin
                    beat_advance = 1'b1;
                    if (beat_is_last) begin
                        state_next     = IDLE;
                        last_handshake = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frame context latch, beat counter and tx_done pulse
    always_ff @(posedge m01_axis_aclk) begin
        if (m01_axis_areset) begin
            beat_idx     <= '0;
            len_latched  <= '0;
            seed_latched <= '0;
            tx_done_q    <= 1'b0;
        end else begin
            tx_done_q <= last_handshake;
            if (start_accept) begin
                len_latched  <= frame_len;
                seed_latched <= seed;
                beat_idx     <= '0;
            end else if (beat_advance) begin
                beat_idx <= beat_idx + LEN_WIDTH'(1);
            end
        end
    end

    assign tx_done = tx_done_q;

    // The receiver never back-pressures; it is only held off while in reset.
    assign s01_axis_tready = ~m01_axis_areset;

`ifdef AXIS_FRAME_CHECKER_EN
    logic [LEN_WIDTH-1:0]  rx_idx;
    logic [15:0]           err_q;
    logic                  rx_done_q;
    logic                  rx_handshake;
    logic                  rx_data_err;
    logic                  rx_last_err;
    logic [DATA_WIDTH-1:0] rx_expect;

    // RX expectation: data counts from the latched seed, tlast on the final index
    always_comb begin
        rx_handshake = s01_axis_tvalid && s01_axis_tready;
        rx_expect    = seed_latched + DATA_WIDTH'(rx_idx);
        rx_data_err  = (s01_axis_tdata != rx_expect);
        rx_last_err  = (s01_axis_tlast != (rx_idx == (len_latched - LEN_WIDTH'(1))));
    end

    // RX index tracking, saturating error counter and rx_done pulse
    always_ff @(posedge m01_axis_aclk) begin
        if (m01_axis_areset) begin
            rx_idx    <= '0;
            err_q     <= '0;
            rx_done_q <= 1'b0;
        end else begin
            rx_done_q <= rx_handshake && s01_axis_tlast;
            if (rx_handshake && (rx_data_err || rx_last_err) && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
            if (start_accept) begin
                rx_idx <= '0;
            end else if (rx_handshake) begin
                rx_idx <= s01_axis_tlast ? '0 : rx_idx + LEN_WIDTH'(1);
            end
        end
    end

    assign err_count = err_q;
    assign rx_done   = rx_done_q;
`else
    logic unused_rx;
    assign unused_rx = ^{s01_axis_tdata, s01_axis_tvalid, s01_axis_tlast};
    assign err_count = '0;
    assign rx_done   = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_generator.sv
// Self-checking bench for axis_frame_generator: a queue-based frame model is
// compared against the DUT every cycle, plus literal checks of directed cases.
module tb_axis_frame_generator;

    localparam int DW = 32;
    localparam int LW = 12;
`ifdef AXIS_FRAME_CHECKER_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic [DW-1:0] seed = '0;
    logic [DW-1:0] m_tdata;
    logic [3:0]    m_tstrb;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b0;
    logic          lb_mode = 1'b0;
    logic [DW-1:0] man_tdata = '0;
    logic          man_tvalid = 1'b0;
    logic          man_tlast = 1'b0;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic          busy;
    logic          tx_done;
    logic          rx_done;
    logic [15:0]   err_count;

    assign s_tdata  = lb_mode ? m_tdata : man_tdata;
    assign s_tvalid = lb_mode ? (m_tvalid & m_tready) : man_tvalid;
    assign s_tlast  = lb_mode ? m_tlast : man_tlast;

    axis_frame_generator #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .m01_axis_aclk   (clk),
        .m01_axis_areset (rst),
        .start           (start),
        .frame_len       (frame_len),
        .seed            (seed),
        .m01_axis_tdata  (m_tdata),
        .m01_axis_tstrb  (m_tstrb),
        .m01_axis_tvalid (m_tvalid),
        .m01_axis_tlast  (m_tlast),
        .m01_axis_tready (m_tready),
        .s01_axis_tdata  (s_tdata),
        .s01_axis_tvalid (s_tvalid),
        .s01_axis_tlast  (s_tlast),
        .s01_axis_tready (s_tready),
        .busy            (busy),
        .tx_done         (tx_done),
        .rx_done         (rx_done),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         txq[$];
    bit            m_txdone = 1'b0;
    bit            m_rxdone = 1'b0;
    bit            m_in_rst = 1'b0;
    int            m_err = 0;
    int            m_rxidx = 0;
    int            m_len = 0;
    logic [DW-1:0] m_seed = '0;

    task automatic model_step();
        bit            accept;
        bit            tx_hs;
        bit            fin;
        bit            rx_hs;
        bit            rx_last;
        bit            bad;
        logic [DW-1:0] rx_data;
        beat_t         b;
        m_in_rst = rst;
        if (rst) begin
            txq.delete();
            m_txdone = 1'b0;
            m_rxdone = 1'b0;
            m_err    = 0;
            m_rxidx  = 0;
            m_len    = 0;
            m_seed   = '0;
            return;
        end
        accept  = (txq.size() == 0) && start && (frame_len != '0);
        tx_hs   = (txq.size() > 0) && m_tready;
        fin     = 1'b0;
        rx_data = '0;
        rx_last = 1'b0;
        if (tx_hs) fin = txq[0].last;
        if (lb_mode) begin
            rx_hs = tx_hs;
            if (tx_hs) begin
                rx_data = txq[0].data;
                rx_last = txq[0].last;
            end
        end else begin
            rx_hs   = man_tvalid;
            rx_data = man_tdata;
            rx_last = man_tlast;
        end
        m_rxdone = CHK && rx_hs && rx_last;
        if (CHK && rx_hs) begin
            bad = (rx_data != (m_seed + DW'(m_rxidx))) ||
                  (rx_last != (m_rxidx == ((m_len + 4095) % 4096)));
            if (bad && m_err < 65535) m_err++;
        end
        if (accept) m_rxidx = 0;
        else if (CHK && rx_hs) m_rxidx = rx_last ? 0 : (m_rxidx + 1) % 4096;
        if (tx_hs) void'(txq.pop_front());
        if (accept) begin
            m_seed = seed;
            m_len  = int'(frame_len);
            for (int i = 0; i < m_len; i++) begin
                b.data = seed + DW'(i);
                b.last = (i == m_len - 1);
                txq.push_back(b);
            end
        end
        m_txdone = fin;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = (txq.size() > 0);
            chk("tvalid",     64'(m_tvalid),  64'(ev));
            chk("busy",       64'(busy),      64'(ev));
            chk("tx_done",    64'(tx_done),   64'(m_txdone));
            chk("rx_done",    64'(rx_done),   64'(m_rxdone));
            chk("err_count",  64'(err_count), 64'(m_err));
            chk("s01_tready", 64'(s_tready),  64'(!rst));
            if (ev) begin
                chk("tdata", 64'(m_tdata), 64'(txq[0].data));
                chk("tlast", 64'(m_tlast), 64'(txq[0].last));
                chk("tstrb", 64'(m_tstrb), 64'(4'hF));
            end else if (m_in_rst) begin
                chk("rst_tdata", 64'(m_tdata), 64'(0));
                chk("rst_tlast", 64'(m_tlast), 64'(0));
                chk("rst_tstrb", 64'(m_tstrb), 64'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max);
        int c = 0;
        m_tready   = 1'b1;
        start      = 1'b0;
        man_tvalid = 1'b0;
        while (busy !== 1'b0 && c < max) begin
            @(negedge clk);
            c++;
        end
        chk("idle_wait", 64'(busy), 64'(0));
        tick();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] exp29 [4];
        logic [DW-1:0] exp32 [3];
        int            idx30 [5];
        bit            pat30 [6];
        exp29 = '{32'h10, 32'h11, 32'h12, 32'h13};
        exp32 = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        idx30 = '{0, 1, 1, 2, 2};
        pat30 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // reset state
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_s01_tready", 64'(s_tready),  64'(0));
        chk("rst_tvalid",     64'(m_tvalid),  64'(0));
        chk("rst_err",        64'(err_count), 64'(0));
        tick();
        rst = 1'b0;
        m_tready = 1'b1;
        tick();

        // seed 0x10, len 4, tready high
        seed = 32'h10; frame_len = 12'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("f29_tdata", 64'(m_tdata), 64'(exp29[i]));
            chk("f29_tlast", 64'(m_tlast), 64'(i == 3));
        end
        @(negedge clk);
        chk("f29_tx_done", 64'(tx_done),  64'(1));
        chk("f29_tvalid",  64'(m_tvalid), 64'(0));
        tick();

        // len 3 with tready toggling 1-0-1-0-1
        seed = 32'hA5A5_0000; frame_len = 12'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            m_tready = pat30[c];
            @(negedge clk);
            if (c < 5) chk("f30_tdata", 64'(m_tdata), 64'(32'hA5A5_0000 + idx30[c]));
            else       chk("f30_tx_done", 64'(tx_done), 64'(1));
            tick();
        end
        m_tready = 1'b1;

        // zero length start is ignored
        seed = 32'h55; frame_len = 12'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("f31_tvalid", 64'(m_tvalid), 64'(0));
            chk("f31_busy",   64'(busy),     64'(0));
        end
        tick();

        // loop-back across the data wrap
        lb_mode = 1'b1;
        seed = 32'hFFFF_FFFE; frame_len = 12'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("f32_tdata", 64'(m_tdata), 64'(exp32[i]));
        end
        @(negedge clk);
        chk("f32_rx_done", 64'(rx_done),   64'(CHK));
        chk("f32_err",     64'(err_count), 64'(0));
        tick();
        lb_mode = 1'b0;

        // corrupted beat 1 with early tlast in a len 4 frame
        m_tready = 1'b0;
        seed = 32'h100; frame_len = 12'd4; start = 1'b1;
        tick();
        start = 1'b0;
        man_tvalid = 1'b1; man_tdata = 32'h100; man_tlast = 1'b0;
        tick();
        man_tdata = 32'h1FF; man_tlast = 1'b1;
        tick();
        man_tdata = 32'h100; man_tlast = 1'b0;
        @(negedge clk);
        chk("f33_rx_done", 64'(rx_done), 64'(CHK));
        tick();
        man_tvalid = 1'b0;
        @(negedge clk);
        chk("f33_err", 64'(err_count), 64'(CHK ? 1 : 0));
        wait_idle(50);

        // reset on beat 2 of a len 8 frame
        seed = 32'h2000; frame_len = 12'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("f34_beat2", 64'(m_tdata), 64'(32'h2002));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("f34_tvalid", 64'(m_tvalid),  64'(0));
        chk("f34_err",    64'(err_count), 64'(0));
        chk("f34_busy",   64'(busy),      64'(0));
        tick();
        seed = 32'h5; frame_len = 12'd2; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("f34_restart", 64'(m_tdata), 64'(32'h5));
        wait_idle(50);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            m_tready   = ($urandom_range(0, 3) != 0);
            start      = ($urandom_range(0, 5) == 0);
            frame_len  = LW'($urandom_range(0, 9));
            seed       = $urandom;
            if ((c % 200) == 0) lb_mode = $urandom_range(0, 1) != 0;
            man_tvalid = $urandom_range(0, 1) != 0;
            man_tlast  = ($urandom_range(0, 4) == 0);
            man_tdata  = ($urandom_range(0, 3) == 0) ? DW'($urandom) : m_seed + DW'(m_rxidx);
            rst        = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        lb_mode = 1'b0;
        wait_idle(100);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
